snn_core_param: RTL and testbench



---
 rtl/snn_core_param.sv | 215 +++++++++++++++++++++
 tb/tb_snn_core_param.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/snn_core_param.sv
// Parametrised input->hidden->output LIF spiking classifier with adaptive thresholds,
// host-loaded weights and a start/done FSM. Optional macro: SNN_LATERAL_INHIBIT_EN.
module snn_core_param #(
  parameter int unsigned NUM_IN        = 8,
  parameter int unsigned NUM_HID       = 4,
  parameter int unsigned NUM_OUT       = 10,
  parameter int unsigned WIDTH_P       = 3,
  parameter int unsigned POT_W         = 8,
  parameter int unsigned THRESHOLD     = 16,
  parameter int unsigned THRESHOLD_INC = 2,
  parameter int unsigned THRESHOLD_DEC = 1,
  parameter int unsigned THRESHOLD_MIN = 8,
  parameter int unsigned LEAK_SHIFT    = 1,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STEPS_W       = 8,
  localparam int unsigned NW  = NUM_IN*NUM_HID + NUM_HID*NUM_OUT,
  localparam int unsigned AW  = $clog2(NW),
  localparam int unsigned OW  = $clog2(NUM_OUT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_we_i,
  input  logic [AW-1:0]      cfg_addr_i,
  input  logic [WIDTH_P-1:0] cfg_wdata_i,
  input  logic               start_i,
  input  logic [STEPS_W-1:0] steps_i,
  input  logic [NUM_IN-1:0]  spike_in_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [OW-1:0]      winner_o,
  output logic               winner_valid_o,
  input  logic [OW-1:0]      count_sel_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [1:0]         dbg_state_o
);
  // Handshake: start_i is a level sampled only in IDLE; done_o is a one-cycle pulse
  // while in DONE, and winner_o/winner_valid_o/counts are stable from then until the next start.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam int unsigned IHW = WIDTH_P + $clog2(NUM_IN);
  localparam int unsigned OHW = WIDTH_P + $clog2(NUM_HID);
  localparam logic [31:0] POT_MAX = 32'((64'd1 << POT_W) - 64'd1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  function automatic logic [POT_W-1:0] integrate(input logic [POT_W-1:0] v, input logic [31:0] cur);
    logic [31:0] s;
    s = 32'(v) - 32'(v >> LEAK_SHIFT) + cur;
    return (s > POT_MAX) ? POT_MAX[POT_W-1:0] : s[POT_W-1:0];
  endfunction

  function automatic logic [POT_W-1:0] thr_up(input logic [POT_W-1:0] thr);
    logic [31:0] t;
    t = 32'(thr) + THRESHOLD_INC;
    return (t > POT_MAX) ? POT_MAX[POT_W-1:0] : t[POT_W-1:0];
  endfunction

  function automatic logic [POT_W-1:0] thr_down(input logic [POT_W-1:0] thr);
    return (32'(thr) >= THRESHOLD_MIN + THRESHOLD_DEC) ? thr - POT_W'(THRESHOLD_DEC)
                                                       : POT_W'(THRESHOLD_MIN);
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH_P-1:0]  w [NW];
  logic [POT_W-1:0]    v_h [NUM_HID];
  logic [POT_W-1:0]    thr_h [NUM_HID];
  logic [POT_W-1:0]    v_o [NUM_OUT];
  logic [POT_W-1:0]    thr_o [NUM_OUT];
  logic [NUM_HID-1:0]  hspk;
  logic [NUM_OUT-1:0]  ospk;
  logic [CNT_W-1:0]    count [NUM_OUT];
  logic [CNT_W-1:0]    count_nxt [NUM_OUT];
  logic [STEPS_W-1:0]  steps_left;
  logic                drain_ph;

  logic [NUM_IN-1:0]   spk_eff;
  logic [IHW-1:0]      cur_h [NUM_HID];
  logic [POT_W-1:0]    vn_h [NUM_HID];
  logic [OHW-1:0]      cur_o [NUM_OUT];
  logic [POT_W-1:0]    vn_o [NUM_OUT];
  logic [NUM_OUT-1:0]  cand_o, fire_o;
  logic [OW-1:0]       best_idx;
  logic [CNT_W-1:0]    best_cnt;
  logic                neuron_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = (steps_i == '0) ? DRAIN : RUN;
      RUN:   if (steps_left == STEPS_W'(1)) state_d = DRAIN;
      DRAIN: if (drain_ph) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    dbg_state_o = state_q;
    neuron_en   = (state_q == RUN) || (state_q == DRAIN);
  end

  // Output layer integrates the hidden spikes registered in the previous cycle.
  always_comb begin
    logic taken;
    spk_eff = (state_q == RUN) ? spike_in_i : '0;
    for (int h = 0; h < NUM_HID; h++) begin
      cur_h[h] = '0;
      for (int i = 0; i < NUM_IN; i++)
        if (spk_eff[i]) cur_h[h] = cur_h[h] + IHW'(w[h*NUM_IN + i]);
      vn_h[h] = integrate(v_h[h], 32'(cur_h[h]));
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      cur_o[o] = '0;
      for (int h = 0; h < NUM_HID; h++)
        if (hspk[h]) cur_o[o] = cur_o[o] + OHW'(w[NUM_IN*NUM_HID + o*NUM_HID + h]);
      vn_o[o]   = integrate(v_o[o], 32'(cur_o[o]));
      cand_o[o] = (vn_o[o] >= thr_o[o]);
    end
    fire_o = cand_o;
    taken  = 1'b0;
`ifdef SNN_LATERAL_INHIBIT_EN
    for (int o = 0; o < NUM_OUT; o++) begin
      if (taken) fire_o[o] = 1'b0;
      taken = taken | cand_o[o];
    end
`endif
  end

  // Argmax looks at the post-update counts so a final increment is not missed.
  always_comb begin
    best_idx = '0;
    best_cnt = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      count_nxt[o] = count[o];
      if ((state_q != IDLE) && ospk[o] && (32'(count[o]) != CNT_MAX))
        count_nxt[o] = count[o] + CNT_W'(1);
    end
    for (int o = 0; o < NUM_OUT; o++)
      if (count_nxt[o] > best_cnt) begin
        best_cnt = count_nxt[o];
        best_idx = OW'(o);
      end
  end

  always_comb begin
    count_o = '0;
    if (32'(count_sel_i) < NUM_OUT) count_o = count[count_sel_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      for (int h = 0; h < NUM_HID; h++) begin
        v_h[h]   <= '0;
        thr_h[h] <= POT_W'(THRESHOLD);
      end
      for (int o = 0; o < NUM_OUT; o++) begin
        v_o[o]   <= '0;
        thr_o[o] <= POT_W'(THRESHOLD);
        count[o] <= '0;
      end
      hspk           <= '0;
      ospk           <= '0;
      steps_left     <= '0;
      drain_ph       <= 1'b0;
      winner_o       <= '0;
      winner_valid_o <= 1'b0;
    end else begin
      drain_ph <= (state_q == DRAIN) && !drain_ph;
      if (cfg_we_i && (state_q == IDLE) && (32'(cfg_addr_i) < NW))
        w[cfg_addr_i] <= cfg_wdata_i;
      if (state_q == IDLE && start_i) begin
        steps_left     <= steps_i;
        winner_valid_o <= 1'b0;
        hspk           <= '0;
        ospk           <= '0;
        for (int h = 0; h < NUM_HID; h++) begin
          v_h[h]   <= '0;
          thr_h[h] <= POT_W'(THRESHOLD);
        end
        for (int o = 0; o < NUM_OUT; o++) begin
          v_o[o]   <= '0;
          thr_o[o] <= POT_W'(THRESHOLD);
          count[o] <= '0;
        end
      end else begin
        for (int o = 0; o < NUM_OUT; o++) count[o] <= count_nxt[o];
      end
      if (state_q == RUN) steps_left <= steps_left - STEPS_W'(1);
      if (neuron_en) begin
        for (int h = 0; h < NUM_HID; h++) begin
          hspk[h]  <= (vn_h[h] >= thr_h[h]);
          v_h[h]   <= (vn_h[h] >= thr_h[h]) ? '0 : vn_h[h];
          thr_h[h] <= (vn_h[h] >= thr_h[h]) ? thr_up(thr_h[h]) : thr_down(thr_h[h]);
        end
        // An inhibited candidate still discharges but adapts as a non-spiker.
        for (int o = 0; o < NUM_OUT; o++) begin
          ospk[o]  <= fire_o[o];
          v_o[o]   <= cand_o[o] ? '0 : vn_o[o];
          thr_o[o] <= fire_o[o] ? thr_up(thr_o[o]) : thr_down(thr_o[o]);
        end
      end
      if (state_q == DONE) begin
        winner_o       <= best_idx;
        winner_valid_o <= (best_cnt != '0);
      end
    end
  end
endmodule

// File: tb/tb_snn_core_param.sv
// Directed bench for snn_core_param: reset state, zero-weight run, single-path run,
// tie/inhibition, busy-time config writes, mid-run reset and zero-step run.
module tb_snn_core_param;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cfg_we_i;
  logic [6:0] cfg_addr_i;
  logic [2:0] cfg_wdata_i;
  logic       start_i;
  logic [7:0] steps_i;
  logic [7:0] spike_in_i;
  logic       busy_o, done_o, winner_valid_o;
  logic [3:0] winner_o;
  logic [3:0] count_sel_i;
  logic [7:0] count_o;
  logic [1:0] dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  snn_core_param dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .start_i(start_i), .steps_i(steps_i),
    .spike_in_i(spike_in_i), .busy_o(busy_o), .done_o(done_o), .winner_o(winner_o),
    .winner_valid_o(winner_valid_o), .count_sel_i(count_sel_i), .count_o(count_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic wr(input logic [6:0] addr, input logic [2:0] data);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_wdata_i = data;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
  endtask

  task automatic expect_counts(input logic [7:0] c3, input logic [7:0] c5);
    for (int o = 0; o < 10; o++)
      exp_q.push_back(o == 3 ? c3 : (o == 5 ? c5 : 8'd0));
  endtask

  task automatic check_counts(input string tag);
    for (int o = 0; o < 10; o++) begin
      count_sel_i = 4'(o);
      #1;
      check($sformatf("%s count[%0d]", tag, o), 32'(count_o), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic run(input string tag, input int steps, input logic [7:0] spk,
                     input int restart_at, input int wr_at, input logic [6:0] wr_addr,
                     input logic [2:0] wr_data, input int exp_win, input int exp_valid);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    @(negedge clk_i);
    start_i = 1'b1; steps_i = 8'(steps); spike_in_i = spk;
    for (int k = 1; k <= steps + 10; k++) begin
      @(negedge clk_i);
      start_i     = (k == restart_at);
      cfg_we_i    = (k == wr_at);
      cfg_addr_i  = wr_addr;
      cfg_wdata_i = wr_data;
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    start_i = 1'b0; cfg_we_i = 1'b0;
    check({tag, " done_at"}, 32'(done_at), 32'(steps + 3));
    check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_cnt"}, 32'(busy_cnt), 32'(steps + 3));
    check_counts(tag);
    check({tag, " winner"}, 32'(winner_o), 32'(exp_win));
    check({tag, " valid"}, 32'(winner_valid_o), 32'(exp_valid));
  endtask

  initial begin
    int done_seen;
    rst_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
    start_i = 1'b0; steps_i = '0; spike_in_i = '0; count_sel_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst done", 32'(done_o), 32'd0);
    check("rst state", 32'(dbg_state_o), 32'd0);
    check("rst winner", 32'(winner_o), 32'd0);
    check("rst valid", 32'(winner_valid_o), 32'd0);
    expect_counts(8'd0, 8'd0);
    check_counts("rst");

    expect_counts(8'd0, 8'd0);
    run("zero_w", 10, 8'hFF, 0, 0, 7'd0, 3'd0, 0, 0);

    wr(7'd0, 3'd7);   // w_in[0->0]
    wr(7'd44, 3'd7);  // w_hid[0->3]
    expect_counts(8'd2, 8'd0);
    run("single", 20, 8'h01, 0, 0, 7'd0, 3'd0, 3, 1);
    count_sel_i = 4'd10; #1;
    check("sel10", 32'(count_o), 32'd0);
    count_sel_i = 4'd15; #1;
    check("sel15", 32'(count_o), 32'd0);

    wr(7'd52, 3'd7);  // w_hid[0->5]
`ifdef SNN_LATERAL_INHIBIT_EN
    expect_counts(8'd2, 8'd0);
`else
    expect_counts(8'd2, 8'd2);
`endif
    run("tie", 20, 8'h01, 0, 0, 7'd0, 3'd0, 3, 1);

    // Busy-time write of 0 to addr 0 and a second start must both be ignored.
`ifdef SNN_LATERAL_INHIBIT_EN
    expect_counts(8'd2, 8'd0);
`else
    expect_counts(8'd2, 8'd2);
`endif
    run("busy_wr", 20, 8'h01, 8, 5, 7'd0, 3'd0, 3, 1);

    wr(7'd72, 3'd0);
    wr(7'd127, 3'd0);
`ifdef SNN_LATERAL_INHIBIT_EN
    expect_counts(8'd2, 8'd0);
`else
    expect_counts(8'd2, 8'd2);
`endif
    run("oor_wr", 20, 8'h01, 0, 0, 7'd0, 3'd0, 3, 1);

    // Mid-run reset at RUN cycle 5.
    @(negedge clk_i);
    start_i = 1'b1; steps_i = 8'd20; spike_in_i = 8'h01;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mrst busy", 32'(busy_o), 32'd0);
    check("mrst state", 32'(dbg_state_o), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (done_o) done_seen++;
      @(negedge clk_i);
    end
    check("mrst no_done", 32'(done_seen), 32'd0);
    check("mrst winner", 32'(winner_o), 32'd0);
    check("mrst valid", 32'(winner_valid_o), 32'd0);
    expect_counts(8'd0, 8'd0);
    check_counts("mrst");
    expect_counts(8'd0, 8'd0);
    run("post_rst", 10, 8'hFF, 0, 0, 7'd0, 3'd0, 0, 0);

    expect_counts(8'd0, 8'd0);
    run("steps0", 0, 8'hFF, 0, 0, 7'd0, 3'd0, 0, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
